// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mips_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D,
    OWN_LD
  } owner_e;

  typedef enum logic {
    MODE_RUN,
    MODE_LOAD
  } mode_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency RAM between instruction fetch,
// MEM-stage data access and the program loader; stalls the core when denied.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              r_st,
  input  logic              ld_mode,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  mode_e               mode_q, mode_d;
  owner_e              tag_q, tag_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                fetch_first;

  // State register: mode, read-owner tag and fetch starvation count
  always_ff @(posedge clk or negedge r_st) begin
    if (!r_st) begin
      mode_q   <= MODE_RUN;
      tag_q    <= OWN_NONE;
      starve_q <= '0;
    end else begin
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  // Next-state, grant selection and RAM port mux
  always_comb begin
    mode_d      = mode_q;
    tag_d       = OWN_NONE;
    starve_d    = starve_q;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    ld_gnt      = 1'b0;
    m_addr      = '0;
    m_we        = 1'b0;
    m_wdata     = '0;
    fetch_first = (starve_q == STARVE_W'(STARVE_MAX));

    // Reset forces every grant low immediately, not only at the next edge
    if (r_st) begin
      case (mode_q)
        MODE_RUN: begin
          if (ld_mode) mode_d = MODE_LOAD;
          if (i_req && (fetch_first || !d_req)) i_gnt = 1'b1;
          else if (d_req)                       d_gnt = 1'b1;
        end
        MODE_LOAD: begin
          if (!ld_mode) mode_d = MODE_RUN;
          if (ld_req)   ld_gnt = 1'b1;
        end
        default: ;
      endcase
    end

    if (i_gnt) begin
      m_addr = i_addr;
      tag_d  = OWN_I;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_wdata = d_wdata;
      tag_d   = d_we ? OWN_NONE : OWN_D;
    end else if (ld_gnt) begin
      m_addr  = ld_addr;
      m_we    = ld_we;
      m_wdata = ld_wdata;
      tag_d   = ld_we ? OWN_NONE : OWN_LD;
    end

    // Count consecutive denied fetches in RUN, saturating at the threshold
    if (i_gnt) begin
      starve_d = '0;
    end else if (mode_q == MODE_RUN && mode_d == MODE_LOAD) begin
      starve_d = '0;
    end else if (mode_q == MODE_RUN && i_req && !fetch_first) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign stall     = r_st & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

  assign i_rvalid  = (tag_q == OWN_I);
  assign d_rvalid  = (tag_q == OWN_D);
  assign ld_rvalid = (tag_q == OWN_LD);

  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign ld_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural RAM and
// a high-level reference model of grants, stall and read responses.
module tb_mem_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned SMAX = 3;

  logic          clk = 1'b0;
  logic          r_st;
  logic          ld_mode;
  logic          i_req, d_req, d_we, ld_req, ld_we;
  logic [AW-1:0] i_addr, d_addr, ld_addr;
  logic [DW-1:0] d_wdata, ld_wdata;
  logic          i_gnt, d_gnt, ld_gnt;
  logic          i_rvalid, d_rvalid, ld_rvalid;
  logic [DW-1:0] i_rdata, d_rdata, ld_rdata;
  logic          stall;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .r_st(r_st), .ld_mode(ld_mode),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .stall(stall), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    return (a * 16'h3B1D) ^ 16'h5A5A;
  endfunction

  // Unified RAM: one-cycle read latency, unwritten words hold init_pat
  logic [DW-1:0] ram   [0:65535];
  bit            ram_v [0:65535];
  always @(posedge clk) begin
    if (m_we) begin
      ram[m_addr]   <= m_wdata;
      ram_v[m_addr] <= 1'b1;
    end
    m_rdata <= ram_v[m_addr] ? ram[m_addr] : init_pat(m_addr);
  end

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_mem [0:65535];
  bit            mdl_load;
  int            losses;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: checks rvalid/rdata against the scoreboard each cycle
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [DW-1:0] rd;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      chk("i_rvalid", 32'(i_rvalid), 32'(e.port == 1));
      chk("d_rvalid", 32'(d_rvalid), 32'(e.port == 2));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(e.port == 3));
      rd = (e.port == 1) ? i_rdata : (e.port == 2) ? d_rdata : ld_rdata;
      chk("rdata", 32'(rd), 32'(e.data));
    end else begin
      chk("no_rvalid", 32'({i_rvalid, d_rvalid, ld_rvalid}), 32'(0));
    end
  end

  task automatic set_idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic model_reset();
    mdl_load = 1'b0;
    losses   = 0;
    sb_q.delete();
  endtask

  // One clock of stimulus: inputs already driven, check at negedge
  task automatic step();
    int            win;
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] wd;
    @(negedge clk);
    win = 0;
    if (mdl_load) begin
      if (ld_req) win = 3;
    end else if (i_req && d_req) begin
      win = (losses == int'(SMAX)) ? 1 : 2;
    end else if (d_req) begin
      win = 2;
    end else if (i_req) begin
      win = 1;
    end
    chk("i_gnt", 32'(i_gnt), 32'(win == 1));
    chk("d_gnt", 32'(d_gnt), 32'(win == 2));
    chk("ld_gnt", 32'(ld_gnt), 32'(win == 3));
    chk("stall", 32'(stall), 32'((i_req && win != 1) || (d_req && win != 2)));
    case (win)
      1:       begin a = i_addr;  we = 1'b0;  wd = '0;       end
      2:       begin a = d_addr;  we = d_we;  wd = d_wdata;  end
      3:       begin a = ld_addr; we = ld_we; wd = ld_wdata; end
      default: begin a = '0;      we = 1'b0;  wd = '0;       end
    endcase
    chk("m_we", 32'(m_we), 32'(we));
    chk("m_addr", 32'(m_addr), 32'(a));
    if (we) chk("m_wdata", 32'(m_wdata), 32'(wd));
    if (win != 0) begin
      if (we) ref_mem[a] = wd;
      else    sb_q.push_back('{due: cyc + 1, port: win, data: ref_mem[a]});
    end
    if (win == 1)                       losses = 0;
    else if (!mdl_load && ld_mode)      losses = 0;
    else if (!mdl_load && i_req && losses < int'(SMAX)) losses++;
    mdl_load = ld_mode;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) ref_mem[k] = init_pat(AW'(k));
    r_st = 1'b0; ld_mode = 1'b0; set_idle();
    i_addr = '0; d_addr = '0; ld_addr = '0; d_wdata = '0; ld_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset must see no grant, no stall, no write
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; ld_req = 1'b1;
    #1;
    chk("rst_i_gnt", 32'(i_gnt), 32'(0));
    chk("rst_d_gnt", 32'(d_gnt), 32'(0));
    chk("rst_ld_gnt", 32'(ld_gnt), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_m_we", 32'(m_we), 32'(0));
    set_idle();
    @(posedge clk);
    #1;
    r_st = 1'b1;

    // First fetch after reset
    i_req = 1'b1; i_addr = 16'h0000; step();
    set_idle(); step();

    // Contention: data wins
    i_req = 1'b1; i_addr = 16'h0004; d_req = 1'b1; d_addr = 16'h0010; step();
    set_idle(); step();

    // Lone fetch clears the starvation count, then sustained contention
    i_req = 1'b1; i_addr = 16'h0006; step();
    i_req = 1'b1; i_addr = 16'h0004; d_req = 1'b1; d_addr = 16'h0010;
    repeat (5) step();
    set_idle(); step();

    // Data write then fetch of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0002; d_wdata = 16'hF00F; step();
    set_idle(); i_req = 1'b1; i_addr = 16'h0002; step();
    set_idle(); step();

    // Load mode: loader writes, core fetch is frozen
    ld_mode = 1'b1; i_req = 1'b1; i_addr = 16'h0008; step();
    step();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0000; ld_wdata = 16'h2800; step();
    ld_we = 1'b0; step();
    set_idle(); ld_mode = 1'b0; step();
    i_req = 1'b1; i_addr = 16'h0000; step();
    set_idle(); step();

    // Mode switch with a data read in flight
    d_req = 1'b1; d_addr = 16'h0010; ld_mode = 1'b1; step();
    set_idle(); step();
    ld_mode = 1'b0; step();
    step();

    // Reset while a read response is being presented
    d_req = 1'b1; d_addr = 16'h0005; step();
    chk("pre_rst_d_rvalid", 32'(d_rvalid), 32'(1));
    set_idle(); r_st = 1'b0; model_reset();
    #1;
    chk("mid_rst_d_rvalid", 32'(d_rvalid), 32'(0));
    chk("mid_rst_m_we", 32'(m_we), 32'(0));
    @(posedge clk);
    #1;
    r_st = 1'b1;
    step();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) ld_mode = ~ld_mode;
      i_req    = 1'($urandom_range(0, 1));
      i_addr   = AW'($urandom_range(0, 31));
      d_req    = 1'($urandom_range(0, 1));
      d_we     = 1'($urandom_range(0, 1));
      d_addr   = AW'($urandom_range(0, 31));
      d_wdata  = DW'($urandom);
      ld_req   = 1'($urandom_range(0, 1));
      ld_we    = 1'($urandom_range(0, 1));
      ld_addr  = AW'($urandom_range(0, 31));
      ld_wdata = DW'($urandom);
      step();
    end
    set_idle(); ld_mode = 1'b0;
    step(); step(); step();
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares a single-port, one-cycle-read-latency unified memory between the `mips` core's instruction-fetch port, its MEM-stage data port and a program-loader port. It sits between `mips` and the unified RAM, which replaces the separate `instruction_memory` and `data_memory` instances. It also drives a stall to the core whenever a core request is denied.

## Interface
Parameters:
- ADDR_W, 16, address width of all ports
- DATA_W, 16, data width of all ports
- STARVE_MAX, 3, consecutive denied fetch cycles before fetch outranks data (1..15)

Ports:
- clk  in  1  clock, rising edge
- r_st  in  1  reset, asynchronous assert, active-low
- ld_mode  in  1  1 = loader owns memory, core ports frozen
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  1  data write when 1
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data accepted
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- ld_req  in  1  loader request
- ld_we  in  1  loader write
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader accepted
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- stall  out  1  core must hold its PC and pipeline registers
- m_addr  out  ADDR_W  RAM address
- m_we  out  1  RAM write strobe
- m_wdata  out  DATA_W  RAM write data
- m_rdata  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- Mode FSM, two states. RUN→LOAD when ld_mode=1; LOAD→RUN when ld_mode=0. The state register updates at the clock edge; the arbitration path uses the registered state.
- RUN priority: data > fetch. Exception: when starve_cnt == STARVE_MAX, fetch > data.
- starve_cnt (4 bits) increments on each RUN cycle with i_req & ~i_gnt and saturates at STARVE_MAX. It clears on i_gnt or on entry to LOAD.
- LOAD: only ld_req is granted. i_gnt and d_gnt are 0. In RUN, ld_gnt is 0.
- At most one grant per cycle. The winner drives m_addr, m_we and m_wdata combinationally. With no winner: m_we=0, m_addr=0, m_wdata=0. Fetch never writes.
- An owner tag register (none/I/D/LD) records a granted read. The next cycle, that port's rvalid=1 and its rdata=m_rdata. A granted write sets the tag to none and produces no rvalid.
- All rdata outputs drive m_rdata unconditionally. Only rvalid qualifies them.
- stall = (i_req & ~i_gnt) | (d_req & ~d_gnt), combinational.

## Timing
- Reset values: state=RUN, starve_cnt=0, tag=none, all rvalid=0, all gnt=0, stall=0, m_we=0.
- Grant is combinational in the request cycle t. Read data and rvalid appear at t+1. Sustained throughput is one access per cycle.
- Simultaneous i_req and d_req in RUN: d wins and stall=1. After STARVE_MAX consecutive losses, fetch wins the next contended cycle.
- Mode switch with a read outstanding: the response is still delivered at t+1 to the tagged owner. Switching does not cancel it.
- Reset asserted mid-read: the tag clears immediately and no rvalid is produced after reset.
- A request whose address is held across stall cycles is re-arbitrated each cycle. No request queueing.

## Structure
- Package `mips_mem_pkg`: owner enum (OWN_NONE, OWN_I, OWN_D, OWN_LD), mode enum (MODE_RUN, MODE_LOAD), and the defaults for ADDR_W and DATA_W.
- Single flat module. No sub-module is warranted; the starvation counter stays inline.

## Test plan
- Reset: r_st=0 mid-cycle → all gnt and rvalid 0, m_we=0 immediately. After release, the first i_req to 0x0000 → i_gnt=1, and i_rvalid=1 with RAM[0] the next cycle.
- Contention: i_req@0x0004 and d_req read@0x0010 in the same cycle → d_gnt=1, i_gnt=0, stall=1. Next cycle d_rvalid=1 with RAM[0x10].
- Starvation: i_req and d_req held for 5 cycles, STARVE_MAX=3 → d granted cycles 0–2, i granted cycle 3, starve_cnt back to 0.
- Write: d_req, d_we=1, d_addr=0x0002, d_wdata=0xF00F → m_we=1 that cycle, no d_rvalid. A later fetch of 0x0002 returns 0xF00F.
- Load mode: ld_mode=1 with i_req pending → i_gnt=0, stall=1. Loader writes 0x2800 to 0x0000 with ld_gnt=1. After ld_mode=0, a fetch of 0x0000 returns 0x2800.
- Switch with read in flight: d read granted at t, ld_mode=1 at t → d_rvalid=1 at t+1 and ld_rvalid=0.
